// File: rtl/mult8x8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult8x8_seq_ctrl
//
// Sequential 8x8 unsigned multiplier controller. The product is built from four
// 4x4 nibble products that are accumulated over four CALC cycles. The
// accumulation uses an external 16-bit adder: the block presents the shifted
// partial product on adder_a and the running accumulator on adder_b, and then
// registers adder_sum back into the accumulator.
//
// Ports
//   clk        in   1   rising-edge clock for all state
//   reset      in   1   synchronous active-high reset
//   start      in   1   begin a multiply (honoured only in IDLE or DONE)
//   dataa      in   8   unsigned multiplicand, captured on an accepted start
//   datab      in   8   unsigned multiplier, captured on an accepted start
//   adder_a    out 16   shifted partial product (0 outside CALC)
//   adder_b    out 16   running accumulator
//   adder_sum  in  16   external adder result (adder_a + adder_b mod 2^16)
//   product    out 16   accumulator; the final product while in DONE
//   busy       out  1   high in CALC
//   done_flag  out  1   high in DONE
//
// Optional feature
//   MULT_EARLY_ZERO_EN  when defined, an accepted start with a zero operand
//                       goes straight to DONE with a zero accumulator.
// -----------------------------------------------------------------------------
module mult8x8_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [15:0] adder_a,
    output logic [15:0] adder_b,
    input  logic [15:0] adder_sum,
    output logic [15:0] product,
    output logic        busy,
    output logic        done_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  step_reg, step_next;
    logic [7:0]  a_reg, a_next;
    logic [7:0]  b_reg, b_next;
    logic [15:0] acc_reg, acc_next;

    logic [15:0] pp_cand [4];
    logic        zero_skip;

    // One candidate partial product per step. Step index bit 0 selects the
    // multiplicand nibble, bit 1 the multiplier nibble; the shift is the sum
    // of the two nibble weights.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp
            localparam int ASEL  = gi % 2;
            localparam int BSEL  = gi / 2;
            localparam int SHIFT = 4 * (ASEL + BSEL);

            logic [3:0] nib_a;
            logic [3:0] nib_b;
            logic [7:0] nib_prod;

            assign nib_a       = a_reg[4*ASEL +: 4];
            assign nib_b       = b_reg[4*BSEL +: 4];
            assign nib_prod    = {4'h0, nib_a} * {4'h0, nib_b};
            assign pp_cand[gi] = {8'h00, nib_prod} << SHIFT;
        end
    endgenerate

`ifdef MULT_EARLY_ZERO_EN
    assign zero_skip = (dataa == 8'h00) || (datab == 8'h00);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_next     = dataa;
                    b_next     = datab;
                    acc_next   = 16'h0000;
                    step_next  = 2'd0;
                    state_next = zero_skip ? DONE : CALC;
                end
            end
            CALC: begin
                // start is deliberately not looked at here.
                acc_next  = adder_sum;
                step_next = step_reg + 2'd1;
                if (step_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            step_reg  <= 2'd0;
            a_reg     <= 8'h00;
            b_reg     <= 8'h00;
            acc_reg   <= 16'h0000;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
        end
    end

    assign adder_a   = (state_reg == CALC) ? pp_cand[step_reg] : 16'h0000;
    assign adder_b   = acc_reg;
    assign product   = acc_reg;
    assign busy      = (state_reg == CALC);
    assign done_flag = (state_reg == DONE);

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult8x8_seq_ctrl
//
// Bench for mult8x8_seq_ctrl with the external 16-bit adder modelled inline.
// Stimulus pushes the expected product and latency into a queue; a monitor
// pops and compares whenever a multiply completes (done_flag rises, or stays
// high after a start accepted in DONE). Per-cycle invariants are checked too.
// -----------------------------------------------------------------------------
module tb_mult8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic [15:0] adder_sum;
    logic [15:0] product;
    logic        busy;
    logic        done_flag;

    mult8x8_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_sum (adder_sum),
        .product   (product),
        .busy      (busy),
        .done_flag (done_flag)
    );

    // External adder.
    assign adder_sum = adder_a + adder_b;

    always #5 clk = ~clk;

`ifdef MULT_EARLY_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 4;
`endif

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          issue;
        logic [7:0]  a;
        logic [7:0]  b;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   pushed  = 0;
    int   popped  = 0;
    int   cyc     = 0;
    bit   mon_en  = 0;
    bit   prev_done = 0;
    bit   prev_acc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each completion.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((!busy && adder_a !== 16'h0000) || (busy && done_flag)) begin
                errors++;
                $display("FAIL invariant: busy=%b done_flag=%b adder_a=%h, required adder_a=0 when not busy and flags exclusive",
                         busy, done_flag, adder_a);
            end
            if (done_flag && (!prev_done || prev_acc)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: product=%h, required no completion", product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    popped++;
                    $display("txn a=%h b=%h product=%h exp=%h latency=%0d exp_latency=%0d",
                             e.a, e.b, product, e.prod, cyc - e.issue, e.lat);
                    check16("product", product, e.prod);
                    checks++;
                    if (cyc - e.issue != e.lat) begin
                        errors++;
                        $display("FAIL latency: got %0d, required %0d", cyc - e.issue, e.lat);
                    end
                end
            end
            prev_done = done_flag;
            prev_acc  = start && !busy;
        end
    end

    // Drive a start for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input int lat, input bit do_push);
        @(posedge clk); #1;
        start = 1'b1;
        dataa = a;
        datab = b;
        if (do_push) begin
            sb.push_back('{exp_p, lat, cyc + 1, a, b});
            pushed++;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && popped != pushed; i++) @(negedge clk);
        if (popped != pushed) begin
            checks++;
            errors++;
            $display("FAIL timeout: completions %0d, required %0d", popped, pushed);
            sb.delete();
            popped = pushed;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dataa = 8'h00;
        datab = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check16("reset_product", product, 16'h0000);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done_flag, 1'b0);
        check16("reset_adder_a", adder_a, 16'h0000);
        mon_en = 1;

        // Scenario 1: 0x12*0x34, busy for four cycles then DONE.
        issue(8'h12, 8'h34, 16'h03A8, 4, 1);
        for (int k = 0; k < 4; k++) begin
            check1("s1_busy", busy, 1'b1);
            @(posedge clk); #1;
        end
        check1("s1_done", done_flag, 1'b1);
        check16("s1_product", product, 16'h03A8);
        wait_done();

        // Scenario 2: 0xFF*0xFF with accumulator trace
        // E1, E1+E10=EF1, EF1+E10=1D01, 1D01+E100=FE01.
        issue(8'hFF, 8'hFF, 16'hFE01, 4, 1);
        @(posedge clk); #1; check16("s2_step0", product, 16'h00E1);
        @(posedge clk); #1; check16("s2_step1", product, 16'h0EF1);
        @(posedge clk); #1; check16("s2_step2", product, 16'h1D01);
        @(posedge clk); #1; check16("s2_step3", product, 16'hFE01);
        wait_done();

        // Scenario 3: reset while in step 2 of 0xA5*0x3C.
        issue(8'hA5, 8'h3C, 16'h0000, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check16("s3_product", product, 16'h0000);
        check1("s3_busy", busy, 1'b0);
        check1("s3_done", done_flag, 1'b0);
        check16("s3_adder_a", adder_a, 16'h0000);

        // Scenario 4: start pulse during CALC ignored; restart from DONE.
        issue(8'h12, 8'h34, 16'h03A8, 4, 1);
        @(posedge clk); #1;
        start = 1'b1;
        dataa = 8'hAA;
        datab = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        issue(8'h0F, 8'h10, 16'h00F0, 4, 1);
        wait_done();

        // Scenario 5: zero operand.
        issue(8'h00, 8'h7B, 16'h0000, ZERO_LAT, 1);
        wait_done();

        // Scenario 6: random operand pairs, some forced to zero.
        for (int n = 0; n < 200; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (n % 37 == 5) ra = 8'h00;
            if (n % 41 == 7) rb = 8'h00;
            issue(ra, rb, 16'(ra) * 16'(rb),
                  (ra == 8'h00 || rb == 8'h00) ? ZERO_LAT : 4, 1);
            wait_done();
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d pending, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
